rf_write_arbiter: RTL and testbench

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

---
 rtl/rf_write_arbiter_if.sv | 39 +++
 rtl/rf_write_arbiter.sv | 85 ++++++++
 tb/tb_rf_write_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_write_arbiter_if.sv
// Register-file write port bundle: two writeback requesters in, one registered
// register-file write out, plus busy and FSM state for observation.
interface rf_write_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  // Handshake: a requester raises Req with stable Addr/Data and holds them until
  // it sees Ack high in a cycle; Ack is the capture strobe, so the transfer
  // completes in that cycle. Req still high in the following cycle is a new write.
  logic              RFWARB_Req0;
  logic [ADDR_W-1:0] RFWARB_Addr0;
  logic [DATA_W-1:0] RFWARB_Data0;
  logic              RFWARB_Req1;
  logic [ADDR_W-1:0] RFWARB_Addr1;
  logic [DATA_W-1:0] RFWARB_Data1;
  logic              RFWARB_Ack0;
  logic              RFWARB_Ack1;
  logic              RFWARB_RegFile_Write;
  logic [ADDR_W-1:0] RFWARB_RegFile_Addr;
  logic [DATA_W-1:0] RFWARB_RegFile_Data;
  logic              RFWARB_Busy;
  logic [1:0]        RFWARB_State;

  modport master (
    output RFWARB_Req0, RFWARB_Addr0, RFWARB_Data0,
    output RFWARB_Req1, RFWARB_Addr1, RFWARB_Data1,
    input  RFWARB_Ack0, RFWARB_Ack1,
    input  RFWARB_RegFile_Write, RFWARB_RegFile_Addr, RFWARB_RegFile_Data,
    input  RFWARB_Busy, RFWARB_State
  );

  modport slave (
    input  RFWARB_Req0, RFWARB_Addr0, RFWARB_Data0,
    input  RFWARB_Req1, RFWARB_Addr1, RFWARB_Data1,
    output RFWARB_Ack0, RFWARB_Ack1,
    output RFWARB_RegFile_Write, RFWARB_RegFile_Addr, RFWARB_RegFile_Data,
    output RFWARB_Busy, RFWARB_State
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter between ALU and load writeback for a single register-file
// write port; one write per three cycles (IDLE -> WRITE -> RECOVER).
module rf_write_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic               RFWARB_Clk,
  input  logic               RFWARB_Reset,
  rf_write_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t            state;
  state_t            next_state;
  logic              last_grant;
  logic              grant0;
  logic              grant1;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              rf_write;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;

  always_comb begin
    next_state = state;
    grant0     = 1'b0;
    grant1     = 1'b0;
    case (state)
      IDLE: begin
        if (!RFWARB_Reset) begin
          // On a tie the requester that did not win last time goes first.
          if (bus.RFWARB_Req0 && bus.RFWARB_Req1) begin
            grant0 = last_grant;
            grant1 = !last_grant;
          end else begin
            grant0 = bus.RFWARB_Req0;
            grant1 = bus.RFWARB_Req1;
          end
          if (grant0 || grant1) next_state = WRITE;
        end
      end
      WRITE:   next_state = RECOVER;
      RECOVER: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign sel_addr = grant1 ? bus.RFWARB_Addr1 : bus.RFWARB_Addr0;
  assign sel_data = grant1 ? bus.RFWARB_Data1 : bus.RFWARB_Data0;

  always_ff @(posedge RFWARB_Clk) begin
    if (RFWARB_Reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      rf_write   <= 1'b0;
      rf_addr    <= '0;
      rf_data    <= '0;
    end else begin
      state <= next_state;
      if (grant0 || grant1) begin
        last_grant <= grant1;
        rf_addr    <= sel_addr;
        rf_data    <= sel_data;
        // x0 is hardwired zero: the grant is consumed but nothing is written.
        rf_write   <= (sel_addr != '0);
      end else begin
        rf_write   <= 1'b0;
      end
    end
  end

  assign bus.RFWARB_Ack0          = grant0;
  assign bus.RFWARB_Ack1          = grant1;
  assign bus.RFWARB_RegFile_Write = rf_write;
  assign bus.RFWARB_RegFile_Addr  = rf_addr;
  assign bus.RFWARB_RegFile_Data  = rf_data;
  assign bus.RFWARB_Busy          = (state != IDLE);
  assign bus.RFWARB_State         = state;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus randomized
// traffic compared against a cycle-budget reference model and write scoreboard.
module tb_rf_write_arbiter;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rf_write_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  rf_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .RFWARB_Clk   (clk),
    .RFWARB_Reset (rst),
    .bus          (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a grant blocks the port for two further cycles.
  int                    m_cool = 0;
  bit                    m_last = 1'b1;
  logic                  m_wr   = 1'b0;
  logic [ADDR_W-1:0]     m_addr = '0;
  logic [DATA_W-1:0]     m_data = '0;
  int                    m_win;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  always_comb begin
    m_win = -1;
    if (!rst && m_cool == 0) begin
      if (bus.RFWARB_Req0 && bus.RFWARB_Req1) m_win = m_last ? 0 : 1;
      else if (bus.RFWARB_Req0)               m_win = 0;
      else if (bus.RFWARB_Req1)               m_win = 1;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_cool <= 0;
      m_last <= 1'b1;
      m_wr   <= 1'b0;
      m_addr <= '0;
      m_data <= '0;
      exp_q.delete();
    end else if (m_win >= 0) begin
      m_cool <= 2;
      m_last <= (m_win == 1);
      m_addr <= (m_win == 1) ? bus.RFWARB_Addr1 : bus.RFWARB_Addr0;
      m_data <= (m_win == 1) ? bus.RFWARB_Data1 : bus.RFWARB_Data0;
      m_wr   <= (((m_win == 1) ? bus.RFWARB_Addr1 : bus.RFWARB_Addr0) != '0);
      if (((m_win == 1) ? bus.RFWARB_Addr1 : bus.RFWARB_Addr0) != '0)
        exp_q.push_back((m_win == 1) ? {bus.RFWARB_Addr1, bus.RFWARB_Data1}
                                     : {bus.RFWARB_Addr0, bus.RFWARB_Data0});
    end else begin
      m_cool <= (m_cool > 0) ? m_cool - 1 : 0;
      m_wr   <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                       input logic r1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
    bus.RFWARB_Req0  = r0;
    bus.RFWARB_Addr0 = a0;
    bus.RFWARB_Data0 = d0;
    bus.RFWARB_Req1  = r1;
    bus.RFWARB_Addr1 = a1;
    bus.RFWARB_Data1 = d1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, '0, '0, 0, '0, '0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 5'd3, 32'h1, 1, 5'd4, 32'h2);
    @(negedge clk);
    n_checks++;
    if (bus.RFWARB_Ack0 !== 1'b0 || bus.RFWARB_Ack1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ack: ack0=%b ack1=%b required 0 0", bus.RFWARB_Ack0, bus.RFWARB_Ack1);
    end
    tick();
    rst = 1'b0;
    drive(0, '0, '0, 0, '0, '0);
    @(negedge clk);
    n_checks++;
    if (bus.RFWARB_RegFile_Write !== 1'b0 || bus.RFWARB_RegFile_Addr !== '0 ||
        bus.RFWARB_RegFile_Data !== '0 || bus.RFWARB_Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: write=%b addr=%0d data=%h busy=%b required 0 0 0 0",
               bus.RFWARB_RegFile_Write, bus.RFWARB_RegFile_Addr, bus.RFWARB_RegFile_Data, bus.RFWARB_Busy);
    end
    tick();
  endtask

  task automatic test_single();
    drive(1, 5'd5, 32'hDEADBEEF, 0, '0, '0);
    @(negedge clk);
    n_checks++;
    if (bus.RFWARB_Ack0 !== 1'b1 || bus.RFWARB_Ack1 !== 1'b0 || bus.RFWARB_Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_ack: ack0=%b ack1=%b busy=%b required 1 0 0",
               bus.RFWARB_Ack0, bus.RFWARB_Ack1, bus.RFWARB_Busy);
    end
    tick();
    drive(0, '0, '0, 0, '0, '0);
    @(negedge clk);
    n_checks++;
    if (bus.RFWARB_RegFile_Write !== 1'b1 || bus.RFWARB_RegFile_Addr !== 5'd5 ||
        bus.RFWARB_RegFile_Data !== 32'hDEADBEEF || bus.RFWARB_Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_write: write=%b addr=%0d data=%h busy=%b required 1 5 deadbeef 1",
               bus.RFWARB_RegFile_Write, bus.RFWARB_RegFile_Addr, bus.RFWARB_RegFile_Data, bus.RFWARB_Busy);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (bus.RFWARB_RegFile_Write !== 1'b0 || bus.RFWARB_Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_recover: write=%b busy=%b required 0 1", bus.RFWARB_RegFile_Write, bus.RFWARB_Busy);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (bus.RFWARB_Busy !== 1'b0 || bus.RFWARB_RegFile_Addr !== 5'd5 || bus.RFWARB_RegFile_Data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL single_idle_hold: busy=%b addr=%0d data=%h required 0 5 deadbeef",
               bus.RFWARB_Busy, bus.RFWARB_RegFile_Addr, bus.RFWARB_RegFile_Data);
    end
    tick();
  endtask

  task automatic test_tie();
    do_reset();
    drive(1, 5'd1, 32'h0A0A0A0A, 1, 5'd2, 32'hB0B0B0B0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.RFWARB_Ack0 !== ((i == 0) || (i == 6)) || bus.RFWARB_Ack1 !== (i == 3)) begin
        n_fail++;
        $display("FAIL tie_cycle%0d: ack0=%b ack1=%b required %b %b", i,
                 bus.RFWARB_Ack0, bus.RFWARB_Ack1, (i == 0) || (i == 6), i == 3);
      end
      tick();
    end
    drive(0, '0, '0, 0, '0, '0);
    repeat (3) tick();
  endtask

  task automatic test_x0();
    drive(0, '0, '0, 1, 5'd0, 32'h1234);
    @(negedge clk);
    n_checks++;
    if (bus.RFWARB_Ack1 !== 1'b1 || bus.RFWARB_Ack0 !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_ack: ack0=%b ack1=%b required 0 1", bus.RFWARB_Ack0, bus.RFWARB_Ack1);
    end
    tick();
    drive(0, '0, '0, 0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.RFWARB_RegFile_Write !== 1'b0 || bus.RFWARB_Busy !== (i < 2)) begin
        n_fail++;
        $display("FAIL x0_cycle%0d: write=%b busy=%b required 0 %b", i,
                 bus.RFWARB_RegFile_Write, bus.RFWARB_Busy, i < 2);
      end
      tick();
    end
  endtask

  task automatic test_held();
    drive(1, 5'd3, 32'h11111111, 0, '0, '0);
    @(negedge clk);
    n_checks++;
    if (bus.RFWARB_Ack0 !== 1'b1) begin
      n_fail++;
      $display("FAIL held_ack0: ack0=%b required 1", bus.RFWARB_Ack0);
    end
    tick();
    drive(0, '0, '0, 1, 5'd9, 32'h22222222);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.RFWARB_Ack1 !== (i == 2)) begin
        n_fail++;
        $display("FAIL held_ack1_cycle%0d: ack1=%b required %b", i, bus.RFWARB_Ack1, i == 2);
      end
      tick();
    end
    drive(0, '0, '0, 0, '0, '0);
    @(negedge clk);
    n_checks++;
    if (bus.RFWARB_RegFile_Write !== 1'b1 || bus.RFWARB_RegFile_Addr !== 5'd9 ||
        bus.RFWARB_RegFile_Data !== 32'h22222222) begin
      n_fail++;
      $display("FAIL held_write: write=%b addr=%0d data=%h required 1 9 22222222",
               bus.RFWARB_RegFile_Write, bus.RFWARB_RegFile_Addr, bus.RFWARB_RegFile_Data);
    end
    repeat (3) tick();
  endtask

  task automatic test_midop_reset();
    drive(1, 5'd7, 32'h00000077, 0, '0, '0);
    @(negedge clk);
    tick();
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.RFWARB_RegFile_Write !== 1'b1 || bus.RFWARB_Ack0 !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_write_cycle: write=%b ack0=%b required 1 0", bus.RFWARB_RegFile_Write, bus.RFWARB_Ack0);
    end
    tick();
    rst = 1'b0;
    drive(1, 5'd6, 32'h66, 1, 5'd8, 32'h88);
    @(negedge clk);
    n_checks++;
    if (bus.RFWARB_RegFile_Write !== 1'b0 || bus.RFWARB_RegFile_Addr !== '0 ||
        bus.RFWARB_RegFile_Data !== '0 || bus.RFWARB_Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_after_reset: write=%b addr=%0d data=%h busy=%b required 0 0 0 0",
               bus.RFWARB_RegFile_Write, bus.RFWARB_RegFile_Addr, bus.RFWARB_RegFile_Data, bus.RFWARB_Busy);
    end
    n_checks++;
    if (bus.RFWARB_Ack0 !== 1'b1 || bus.RFWARB_Ack1 !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_tie: ack0=%b ack1=%b required 1 0", bus.RFWARB_Ack0, bus.RFWARB_Ack1);
    end
    tick();
    drive(0, '0, '0, 0, '0, '0);
    repeat (3) tick();
  endtask

  task automatic test_capture();
    drive(1, 5'd4, 32'hAAAA0000, 0, '0, '0);
    @(negedge clk);
    tick();
    drive(0, 5'd4, 32'h5555FFFF, 0, '0, '0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.RFWARB_RegFile_Data !== 32'hAAAA0000 || bus.RFWARB_RegFile_Write !== (i == 0)) begin
        n_fail++;
        $display("FAIL capture_cycle%0d: data=%h write=%b required aaaa0000 %b", i,
                 bus.RFWARB_RegFile_Data, bus.RFWARB_RegFile_Write, i == 0);
      end
      tick();
    end
    tick();
  endtask

  task automatic test_random();
    logic acked0 = 1'b0;
    logic acked1 = 1'b0;
    logic [ADDR_W+DATA_W-1:0] exp;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      if (!bus.RFWARB_Req0 || acked0) begin
        bus.RFWARB_Req0  = ($urandom_range(0, 2) == 0);
        bus.RFWARB_Addr0 = ADDR_W'($urandom_range(0, 31));
        bus.RFWARB_Data0 = $urandom;
      end
      if (!bus.RFWARB_Req1 || acked1) begin
        bus.RFWARB_Req1  = ($urandom_range(0, 2) == 0);
        bus.RFWARB_Addr1 = ADDR_W'($urandom_range(0, 31));
        bus.RFWARB_Data1 = $urandom;
      end
      @(negedge clk);
      n_checks++;
      if (bus.RFWARB_Ack0 !== (m_win == 0) || bus.RFWARB_Ack1 !== (m_win == 1) ||
          bus.RFWARB_Busy !== (m_cool != 0)) begin
        n_fail++;
        $display("FAIL rand_ctrl@%0d: ack0=%b ack1=%b busy=%b required %b %b %b", i,
                 bus.RFWARB_Ack0, bus.RFWARB_Ack1, bus.RFWARB_Busy, m_win == 0, m_win == 1, m_cool != 0);
      end
      n_checks++;
      if (bus.RFWARB_RegFile_Write !== m_wr || bus.RFWARB_RegFile_Addr !== m_addr ||
          bus.RFWARB_RegFile_Data !== m_data) begin
        n_fail++;
        $display("FAIL rand_out@%0d: write=%b addr=%0d data=%h required %b %0d %h", i,
                 bus.RFWARB_RegFile_Write, bus.RFWARB_RegFile_Addr, bus.RFWARB_RegFile_Data, m_wr, m_addr, m_data);
      end
      if (bus.RFWARB_RegFile_Write === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_sb_empty@%0d: write with addr=%0d but no write expected", i, bus.RFWARB_RegFile_Addr);
        end else begin
          exp = exp_q.pop_front();
          if ({bus.RFWARB_RegFile_Addr, bus.RFWARB_RegFile_Data} !== exp) begin
            n_fail++;
            $display("FAIL rand_sb@%0d: got addr=%0d data=%h required addr=%0d data=%h", i,
                     bus.RFWARB_RegFile_Addr, bus.RFWARB_RegFile_Data, exp[ADDR_W+DATA_W-1:DATA_W], exp[DATA_W-1:0]);
          end
        end
      end
      acked0 = bus.RFWARB_Ack0;
      acked1 = bus.RFWARB_Ack1;
      tick();
    end
    rst = 1'b0;
    drive(0, '0, '0, 0, '0, '0);
    repeat (3) tick();
  endtask

  initial begin
    drive(0, '0, '0, 0, '0, '0);
    test_reset();
    test_single();
    test_tie();
    test_x0();
    test_held();
    test_midop_reset();
    test_capture();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
